// File: rtl/mmu_weight_loader.sv
// Systolic-array weight loader: buffers ROWS weight rows from the weight buffer, then
// shifts them into the PE columns last-row-first and waits for the chain to settle.
module mmu_weight_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       w_valid_in,
  output logic                       w_ready_out,
  input  logic [COLS*DATA_WIDTH-1:0] w_data_in,
  output logic [COLS-1:0]            w_wen_out,
  output logic [COLS*DATA_WIDTH-1:0] w_out,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned CntW = $clog2(ROWS + 1);
  localparam int unsigned RowW = COLS * DATA_WIDTH;
  localparam logic [CntW-1:0] LastCnt = CntW'(ROWS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StIssue, StSettle} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RowW-1:0] buf_q [ROWS];
  logic [RowW-1:0] buf_d [ROWS];
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic [COLS-1:0] wen_q, wen_d;
  logic [RowW-1:0] wout_q, wout_d;
  logic            xfer;

  assign xfer = w_valid_in & ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFill;
          cnt_d   = '0;
        end
      end
      StFill: begin
        if (xfer) begin
          for (int unsigned r = 0; r < ROWS; r++) begin
            if (cnt_q == CntW'(r)) buf_d[r] = w_data_in;
          end
          if (cnt_q == LastCnt) begin
            state_d = StIssue;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StIssue: begin
        if (cnt_q == LastCnt) begin
          state_d = StSettle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSettle: begin
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state itself.
    ready_d = (state_d == StFill) && (cnt_d < CntW'(ROWS));
    wen_d   = (state_d == StIssue) ? '1 : '0;
    wout_d  = '0;
    if (state_d == StIssue) begin
      // buf_d, not buf_q: the last row is written on the same edge its issue begins.
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (cnt_d == CntW'(ROWS - 1 - r)) wout_d = buf_d[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      wen_q   <= '0;
      wout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      wen_q   <= wen_d;
      wout_q  <= wout_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign w_ready_out = ready_q;
  assign done        = done_q;
  assign w_wen_out   = wen_q;
  assign w_out       = wout_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mmu_weight_loader.sv
// Directed bench for mmu_weight_loader (ROWS=4, COLS=2) with a 4-deep PE column model.
module tb_mmu_weight_loader;

  localparam int DW   = 16;
  localparam int ROWS = 4;
  localparam int COLS = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 w_valid_in;
  logic                 w_ready_out;
  logic [COLS*DW-1:0]   w_data_in;
  logic [COLS-1:0]      w_wen_out;
  logic [COLS*DW-1:0]   w_out;
  logic                 busy;
  logic                 done;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  logic [DW-1:0] pe [COLS][ROWS];

  typedef struct packed {
    logic [3:0][31:0] rows;
    logic [3:0][31:0] exp_out;
    logic [7:0]       gap;
    logic             spam;
  } vec_t;

  vec_t vecs [4];

  mmu_weight_loader #(
    .DATA_WIDTH(DW),
    .ROWS      (ROWS),
    .COLS      (COLS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .w_valid_in (w_valid_in),
    .w_ready_out(w_ready_out),
    .w_data_in  (w_data_in),
    .w_wen_out  (w_wen_out),
    .w_out      (w_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) n_done <= n_done + 1;
    for (int c = 0; c < COLS; c++) begin
      if (w_wen_out[c]) begin
        pe[c][0] <= w_out[c*DW +: DW];
        for (int i = 1; i < ROWS; i++) pe[c][i] <= pe[c][i-1];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after done.
  task automatic run_load(input vec_t v, input string tag);
    int   k;
    int   t;
    int   d0;
    logic hs;
    d0    = n_done;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_fill"}, 64'(busy), 64'd1);
    k = 0;
    t = 0;
    while (k < ROWS && t < 200) begin
      w_valid_in = (v.gap == 0) || ((t % (int'(v.gap) + 1)) == 0);
      w_data_in  = v.rows[k];
      start      = v.spam;
      hs         = w_valid_in & w_ready_out;
      @(negedge clk);
      if (hs) k++;
      t++;
    end
    w_valid_in = 1'b0;
    if (k < ROWS) chk({tag, ".fill_timeout"}, 64'(k), 64'(ROWS));
    for (int j = 0; j < ROWS; j++) begin
      chk($sformatf("%s.issue%0d_wen", tag, j), 64'(w_wen_out), 64'h3);
      chk($sformatf("%s.issue%0d_wout", tag, j), 64'(w_out), 64'(v.exp_out[j]));
      chk($sformatf("%s.issue%0d_ready", tag, j), 64'(w_ready_out), 64'd0);
      start = v.spam;
      @(negedge clk);
    end
    for (int j = 0; j < ROWS; j++) begin
      chk($sformatf("%s.settle%0d", tag, j),
          64'({w_wen_out, w_out, done, busy, w_ready_out}), 64'({2'b00, 32'h0, 3'b010}));
      start = v.spam;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".done"}, 64'({done, busy}), 64'({1'b1, 1'b0}));
    for (int c = 0; c < COLS; c++) begin
      for (int i = 0; i < ROWS; i++) begin
        chk($sformatf("%s.pe_c%0d_r%0d", tag, c, i), 64'(pe[c][i]),
            64'(v.rows[i][c*DW +: DW]));
      end
    end
    @(negedge clk);
    chk({tag, ".done_drop"}, 64'(done), 64'd0);
    chk({tag, ".done_count"}, 64'(n_done - d0), 64'd1);
  endtask

  initial begin
    int d0;
    vecs[0].rows    = {32'h4444_D003, 32'h3333_C002, 32'h2222_B001, 32'h1111_A000};
    vecs[0].exp_out = {32'h1111_A000, 32'h2222_B001, 32'h3333_C002, 32'h4444_D003};
    vecs[0].gap     = 8'd0;
    vecs[0].spam    = 1'b0;
    vecs[1].rows    = {32'hDEAD_0004, 32'hBEEF_0003, 32'hCAFE_0002, 32'hF00D_0001};
    vecs[1].exp_out = {32'hF00D_0001, 32'hCAFE_0002, 32'hBEEF_0003, 32'hDEAD_0004};
    vecs[1].gap     = 8'd2;
    vecs[1].spam    = 1'b0;
    vecs[2].rows    = {32'h0D0D_0C0C, 32'h0B0B_0A0A, 32'h0909_0808, 32'h0707_0606};
    vecs[2].exp_out = {32'h0707_0606, 32'h0909_0808, 32'h0B0B_0A0A, 32'h0D0D_0C0C};
    vecs[2].gap     = 8'd1;
    vecs[2].spam    = 1'b1;
    vecs[3].rows    = {32'h7FFF_FFFE, 32'h8000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[3].exp_out = {32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0001, 32'h7FFF_FFFE};
    vecs[3].gap     = 8'd0;
    vecs[3].spam    = 1'b0;

    rst        = 1'b1;
    start      = 1'b1;
    w_valid_in = 1'b1;
    w_data_in  = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({w_wen_out, w_out, done, busy, w_ready_out}), 64'd0);
    rst        = 1'b0;
    start      = 1'b0;
    w_valid_in = 1'b0;
    @(negedge clk);
    chk("idle_outputs", 64'({w_wen_out, w_out, done, busy, w_ready_out}), 64'd0);

    // Consecutive entries run back-to-back: each start lands the cycle after done.
    for (int i = 0; i < 4; i++) run_load(vecs[i], $sformatf("vec%0d", i));

    // Abort a load with reset on ISSUE cycle 2.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < ROWS; k++) begin
      w_valid_in = 1'b1;
      w_data_in  = vecs[1].rows[k];
      @(negedge clk);
    end
    w_valid_in = 1'b0;
    chk("abort.issue0_wen", 64'(w_wen_out), 64'h3);
    @(negedge clk);
    @(negedge clk);
    chk("abort.issue2_wout", 64'(w_out), 64'(vecs[1].exp_out[2]));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.after_rst", 64'({w_wen_out, w_out, done, busy, w_ready_out}), 64'd0);
    d0 = n_done;
    repeat (12) @(negedge clk);
    chk("abort.no_done", 64'(n_done - d0), 64'd0);
    chk("abort.idle", 64'({busy, w_ready_out}), 64'd0);
    run_load(vecs[0], "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/mmu_weight_loader.md
MMU_WEIGHT_LOADER -- requirements
Module: mmu_weight_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one weight word.
REQ-002 SHALL have parameter ROWS, default 4, PE rows per column, which is the weight-chain depth; minimum 2.
REQ-003 SHALL have parameter COLS, default 4, number of PE columns driven in parallel.
REQ-004 SHALL have clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have start  input  1  one-cycle request to begin a weight load; honoured only in IDLE.
REQ-007 SHALL have w_valid_in  input  1  weight-row beat valid from the weight buffer.
REQ-008 SHALL have w_ready_out  output  1  loader accepts a beat this cycle.
REQ-009 SHALL have w_data_in  input  COLS*DATA_WIDTH  one weight row; column c in bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have w_wen_out  output  COLS  weight-shift enable to the top PE of each column.
REQ-011 SHALL have w_out  output  COLS*DATA_WIDTH  weight word to the top PE of each column, packed as w_data_in.
REQ-012 SHALL have busy  output  1  high whenever the state is not IDLE.
REQ-013 SHALL have done  output  1  one-cycle pulse when the loaded weights have settled in the array.

Function
REQ-014 SHALL implement the states IDLE, FILL, ISSUE and SETTLE.
REQ-015 SHALL have registered outputs w_wen_out, w_out, done and w_ready_out; busy SHALL be derived from state.
REQ-016 SHALL move IDLE->FILL on the edge where start=1; start in any other state SHALL be ignored with no effect.
REQ-017 FILL SHALL drive w_ready_out=1 while the row count is less than ROWS; a beat transfers when w_valid_in and w_ready_out are both 1.
REQ-018 SHALL store beat k (k=0..ROWS-1, arrival order) into internal row buffer entry k; gaps in w_valid_in SHALL only stall FILL.
REQ-019 SHALL move FILL->ISSUE on the edge of the ROWS-th transfer; w_ready_out SHALL be 0 from the following cycle.
REQ-020 In ISSUE, SHALL drive w_wen_out all-ones for exactly ROWS consecutive cycles with no gaps.
REQ-021 In ISSUE cycle j (j=0..ROWS-1), SHALL drive w_out with buffer entry ROWS-1-j, last row first, so the bottom PE receives row ROWS-1.
REQ-022 SHALL move ISSUE->SETTLE after the last issue cycle; in SETTLE, w_wen_out SHALL be all zeros and w_out zero.
REQ-023 SETTLE SHALL last exactly ROWS cycles, covering chain propagation, then move to IDLE with done=1 for that single cycle.
REQ-024 Outside ISSUE, SHALL hold w_wen_out=0 and w_out=0.
REQ-025 The row counter SHALL be ceil(log2(ROWS+1)) bits wide and SHALL clear on every state entry; it SHALL never wrap within a state.
REQ-026 Total latency from the last FILL transfer to the done pulse SHALL be 2*ROWS+1 cycles.

Reset
REQ-027 With rst=1 at an edge, the block SHALL enter IDLE; w_wen_out, w_out, done, w_ready_out and the counter SHALL be 0, and busy SHALL be 0.
REQ-028 Reset mid-FILL, mid-ISSUE or mid-SETTLE SHALL abort the load immediately, and no done pulse SHALL follow; buffer contents need not be cleared.
REQ-029 rst SHALL take priority over start and over a simultaneous handshake.

Verification
REQ-030 Nominal, ROWS=4, COLS=2: start, then 4 back-to-back beats {r0..r3} -> w_wen_out=2'b11 for 4 cycles with w_out=r3,r2,r1,r0; done 9 cycles after the r3 handshake.
REQ-031 Bubbles: w_valid_in toggled 1,0,0,1,... during FILL -> ISSUE output identical to REQ-030 and contiguous; done only delayed by the bubble count.
REQ-032 start during FILL, ISSUE and SETTLE -> no state change, no extra beat accepted, and exactly one done pulse.
REQ-033 rst asserted on ISSUE cycle 2 -> next cycle w_wen_out=0, busy=0, no done; a fresh start then performs a full correct load.
REQ-034 Chained with a 4-row PE column model: after done, PE row i holds row i of the weights loaded for every column; w_ready_out is never 1 outside FILL.
REQ-035 Back-to-back loads: start on the cycle after done -> second load completes with correct order, and no first-load data leaks into w_out.
